// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the core MEM stage
// and a debug/loader port. Define DMEM_ARB_RR_EN for round-robin arbitration.
module dmem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int WAIT_CYC = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic [DATA_W-1:0] c_rdata,
    output logic              c_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata
);

    localparam int CNT_W = 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    // owner/last_owner encoding: 0 = core, 1 = debug
    state_t              state_q, state_d;
    logic                owner_q, owner_d;
    logic                last_owner_q, last_owner_d;
    logic                we_q, we_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                m_en_q, m_en_d;
    logic                m_we_q, m_we_d;
    logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
    logic [DATA_W-1:0]   m_wdata_q, m_wdata_d;
    logic [DATA_W-1:0]   c_rdata_q, c_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic                d_ack_q, d_ack_d;
    logic                gnt_dbg;
    logic                gnt_we;
    logic                c_done;

    // Pick the winning port for a new transaction
    always_comb begin
`ifdef DMEM_ARB_RR_EN
        gnt_dbg = d_req & (~c_req | ~last_owner_q);
`else
        gnt_dbg = d_req & ~c_req;
`endif
        gnt_we = gnt_dbg ? d_we : c_we;
    end

    // Next-state and registered-output logic of the access sequencer
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        we_d         = we_q;
        cnt_d        = cnt_q;
        m_en_d       = 1'b0;
        m_we_d       = 1'b0;
        m_addr_d     = m_addr_q;
        m_wdata_d    = m_wdata_q;
        c_rdata_d    = c_rdata_q;
        d_rdata_d    = d_rdata_q;
        d_ack_d      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (c_req | d_req) begin
                    owner_d      = gnt_dbg;
                    last_owner_d = gnt_dbg;
                    we_d         = gnt_we;
                    m_en_d       = 1'b1;
                    m_we_d       = gnt_we;
                    m_addr_d     = gnt_dbg ? d_addr : c_addr;
                    m_wdata_d    = gnt_dbg ? d_wdata : c_wdata;
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (we_q) begin
                    d_ack_d = owner_q;
                    state_d = S_DONE;
                end else begin
                    cnt_d   = CNT_W'(WAIT_CYC - 1);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    if (owner_q) begin
                        d_rdata_d = m_rdata;
                    end else begin
                        c_rdata_d = m_rdata;
                    end
                    d_ack_d = owner_q;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any in-flight access
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            we_q         <= 1'b0;
            cnt_q        <= '0;
            m_en_q       <= 1'b0;
            m_we_q       <= 1'b0;
            m_addr_q     <= '0;
            m_wdata_q    <= '0;
            c_rdata_q    <= '0;
            d_rdata_q    <= '0;
            d_ack_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            we_q         <= we_d;
            cnt_q        <= cnt_d;
            m_en_q       <= m_en_d;
            m_we_q       <= m_we_d;
            m_addr_q     <= m_addr_d;
            m_wdata_q    <= m_wdata_d;
            c_rdata_q    <= c_rdata_d;
            d_rdata_q    <= d_rdata_d;
            d_ack_q      <= d_ack_d;
        end
    end

    // Core completion is the DONE cycle of a core-owned access
    always_comb begin
        c_done  = (state_q == S_DONE) & ~owner_q;
        c_stall = c_req & ~c_done;
    end

    assign c_rdata = c_rdata_q;
    assign d_rdata = d_rdata_q;
    assign d_ack   = d_ack_q;
    assign m_en    = m_en_q;
    assign m_we    = m_we_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench for dmem_arbiter.
// DUT a uses WAIT_CYC=1, DUT b uses WAIT_CYC=3 for the mid-wait reset case.
module tb_dmem_arbiter;

    localparam int WA = 1;
    localparam int WB = 3;

    typedef struct {
        bit          dut;
        bit          port;
        bit          we;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst_n, a_c_req, a_c_we, a_c_stall, a_d_req, a_d_we, a_d_ack, a_m_en, a_m_we;
    logic [31:0] a_c_addr, a_c_wdata, a_c_rdata, a_d_addr, a_d_wdata, a_d_rdata;
    logic [31:0] a_m_addr, a_m_wdata, a_m_rdata;
    logic        b_rst_n, b_c_req, b_c_we, b_c_stall, b_d_req, b_d_we, b_d_ack, b_m_en, b_m_we;
    logic [31:0] b_c_addr, b_c_wdata, b_c_rdata, b_d_addr, b_d_wdata, b_d_rdata;
    logic [31:0] b_m_addr, b_m_wdata, b_m_rdata;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYC(WA)) u_a (
        .clk(clk), .reset(a_rst_n),
        .c_req(a_c_req), .c_we(a_c_we), .c_addr(a_c_addr), .c_wdata(a_c_wdata),
        .c_rdata(a_c_rdata), .c_stall(a_c_stall),
        .d_req(a_d_req), .d_we(a_d_we), .d_addr(a_d_addr), .d_wdata(a_d_wdata),
        .d_rdata(a_d_rdata), .d_ack(a_d_ack),
        .m_en(a_m_en), .m_we(a_m_we), .m_addr(a_m_addr), .m_wdata(a_m_wdata),
        .m_rdata(a_m_rdata)
    );

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYC(WB)) u_b (
        .clk(clk), .reset(b_rst_n),
        .c_req(b_c_req), .c_we(b_c_we), .c_addr(b_c_addr), .c_wdata(b_c_wdata),
        .c_rdata(b_c_rdata), .c_stall(b_c_stall),
        .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
        .d_rdata(b_d_rdata), .d_ack(b_d_ack),
        .m_en(b_m_en), .m_we(b_m_we), .m_addr(b_m_addr), .m_wdata(b_m_wdata),
        .m_rdata(b_m_rdata)
    );

    // memory model: mem[i] = 2*i+4 after reset, so addr 8 -> 20, addr 12 -> 28
    logic [31:0] mem [64];
    logic [31:0] pa [WA];
    logic [31:0] pb [WB];
    int          cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (!a_rst_n) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'(i * 2 + 4);
        end else if (a_m_en && a_m_we) begin
            mem[a_m_addr[5:0]] <= a_m_wdata;
        end
        pa[0] <= (a_m_en && !a_m_we) ? mem[a_m_addr[5:0]] : 32'hDEAD_BEEF;
        for (int i = 1; i < WA; i++) pa[i] <= pa[i-1];
    end

    always @(posedge clk) begin
        pb[0] <= (b_m_en && !b_m_we) ? mem[b_m_addr[5:0]] : 32'hDEAD_BEEF;
        for (int i = 1; i < WB; i++) pb[i] <= pb[i-1];
    end

    assign a_m_rdata = pa[WA-1];
    assign b_m_rdata = pb[WB-1];

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    int   exp_n = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cyc %0d)", nm, got, exp, cyc);
        end
    endtask

    task automatic push(input bit dut, input bit port, input bit we,
                        input logic [31:0] data, input int lat);
        exp_t e;
        e.dut  = dut;
        e.port = port;
        e.we   = we;
        e.data = data;
        e.cyc  = cyc + lat;
        sbq.push_back(e);
        exp_n++;
    endtask

    task automatic chk_done(input bit dut, input bit port, input logic [31:0] data);
        exp_t e;
        checks++;
        done_cnt++;
        if (sbq.size() == 0) begin
            errors++;
            $display("FAIL done_unexpected: dut=%0d port=%0d cyc=%0d data=%h, expected none",
                     dut, port, cyc, data);
        end else begin
            e = sbq.pop_front();
            if (e.dut !== dut || e.port !== port || e.cyc != cyc ||
                (!e.we && e.data !== data)) begin
                errors++;
                $display("FAIL done: got dut=%0d port=%0d cyc=%0d data=%h, expected dut=%0d port=%0d cyc=%0d data=%h",
                         dut, port, cyc, data, e.dut, e.port, e.cyc, e.data);
            end
        end
    endtask

    // monitor: every completion pops the scoreboard
    always @(negedge clk) begin
        if (a_c_req && !a_c_stall) chk_done(1'b0, 1'b0, a_c_rdata);
        if (a_d_ack)               chk_done(1'b0, 1'b1, a_d_rdata);
        if (b_c_req && !b_c_stall) chk_done(1'b1, 1'b0, b_c_rdata);
        if (b_d_ack)               chk_done(1'b1, 1'b1, b_d_rdata);
    end

    // returns #1 after the edge that ends the done cycle
    task automatic wait_done(input int target);
        int n;
        n = 0;
        @(posedge clk);
        while (done_cnt < target && n < 300) begin
            @(posedge clk);
            n++;
        end
        if (done_cnt < target) begin
            checks++;
            errors++;
            $display("FAIL timeout: done_cnt %0d expected %0d", done_cnt, target);
        end
        #1;
    endtask

    task automatic a_access(input bit port, input bit we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] expd);
        if (port) begin
            a_d_req = 1'b1; a_d_we = we; a_d_addr = addr; a_d_wdata = wdata;
        end else begin
            a_c_req = 1'b1; a_c_we = we; a_c_addr = addr; a_c_wdata = wdata;
        end
        push(1'b0, port, we, expd, we ? 2 : WA + 2);
        @(negedge clk);
        chk("m_en_req_cycle", a_m_en, 0);
        if (!port) chk("c_stall_c0", a_c_stall, 1);
        @(negedge clk);
        chk("m_en_issue", a_m_en, 1);
        chk("m_we_issue", a_m_we, we);
        chk("m_addr_issue", a_m_addr, addr);
        if (we) chk("m_wdata_issue", a_m_wdata, wdata);
        if (!port) chk("c_stall_c1", a_c_stall, 1);
        @(negedge clk);
        chk("m_en_after", a_m_en, 0);
        chk("m_we_after", a_m_we, 0);
        wait_done(exp_n);
        a_c_req = 1'b0;
        a_d_req = 1'b0;
    endtask

    initial begin
        int base;
        a_rst_n = 1'b0; b_rst_n = 1'b0;
        a_c_req = 1'b1; a_c_we = 1'b0; a_c_addr = '0; a_c_wdata = '0;
        a_d_req = 1'b0; a_d_we = 1'b0; a_d_addr = '0; a_d_wdata = '0;
        b_c_req = 1'b0; b_c_we = 1'b0; b_c_addr = '0; b_c_wdata = '0;
        b_d_req = 1'b0; b_d_we = 1'b0; b_d_addr = '0; b_d_wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_m_en", a_m_en, 0);
        chk("rst_m_we", a_m_we, 0);
        chk("rst_m_addr", a_m_addr, 0);
        chk("rst_m_wdata", a_m_wdata, 0);
        chk("rst_c_rdata", a_c_rdata, 0);
        chk("rst_d_rdata", a_d_rdata, 0);
        chk("rst_d_ack", a_d_ack, 0);
        chk("rst_c_stall", a_c_stall, 1);
        a_c_req = 1'b0;
        @(posedge clk); #1;
        a_rst_n = 1'b1; b_rst_n = 1'b1;
        @(posedge clk); #1;

        a_access(1'b0, 1'b0, 32'd8, 32'd0, 32'd20);
        a_access(1'b0, 1'b1, 32'd16, 32'd5, 32'd0);
        chk("c_rdata_hold", a_c_rdata, 32'd20);
        a_access(1'b0, 1'b0, 32'd16, 32'd0, 32'd5);
        a_access(1'b1, 1'b1, 32'd4, 32'h0000_ABCD, 32'd0);
        a_access(1'b0, 1'b0, 32'd4, 32'd0, 32'h0000_ABCD);
        a_access(1'b1, 1'b0, 32'd16, 32'd0, 32'd5);
        @(posedge clk); #1;

        // contention: both ports hold read requests
        base = exp_n;
        a_c_req = 1'b1; a_c_we = 1'b0; a_c_addr = 32'd8;
        a_d_req = 1'b1; a_d_we = 1'b0; a_d_addr = 32'd12;
`ifdef DMEM_ARB_RR_EN
        for (int k = 0; k < 4; k++)
            push(1'b0, 1'(k % 2), 1'b0, (k % 2) ? 32'd28 : 32'd20, WA + 2 + 4 * k);
        wait_done(base + 4);
        a_c_req = 1'b0;
        a_d_req = 1'b0;
`else
        for (int k = 0; k < 21; k++)
            push(1'b0, (k == 20), 1'b0, (k == 20) ? 32'd28 : 32'd20, WA + 2 + 4 * k);
        wait_done(base + 20);
        a_c_req = 1'b0;
        wait_done(base + 21);
        a_d_req = 1'b0;
`endif
        @(posedge clk); #1;

        // WAIT_CYC=3: reset during WAIT, then reissue
        b_c_req = 1'b1; b_c_we = 1'b0; b_c_addr = 32'd8;
        repeat (3) @(posedge clk);
        #1;
        b_rst_n = 1'b0;
        #1;
        chk("b_rst_m_en", b_m_en, 0);
        chk("b_rst_m_addr", b_m_addr, 0);
        chk("b_rst_c_rdata", b_c_rdata, 0);
        chk("b_rst_c_stall", b_c_stall, 1);
        chk("b_rst_d_ack", b_d_ack, 0);
        repeat (2) @(posedge clk);
        #1;
        b_rst_n = 1'b1;
        push(1'b1, 1'b0, 1'b0, 32'd20, WB + 2);
        wait_done(exp_n);
        b_c_req = 1'b0;
        repeat (4) @(posedge clk);

        chk("sb_empty", 32'(sbq.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
